// File: rtl/execute_stage_ctrl_pkg.sv
// Shared types and widths for the execute-stage control block.
package common;
  localparam int MC_LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC_MC  = 2'd1,
    WAIT_OUT = 2'd2
  } exec_ctrl_state_t;
endpackage

// File: rtl/execute_stage_ctrl_if.sv
// Decode/memory handshake and multicycle-unit control bundle for the execute stage.
interface execute_stage_ctrl_if;
  import common::*;

  logic                in_valid;
  logic                in_multicycle;
  logic [MC_LAT_W-1:0] in_latency;
  logic                out_ready;
  logic                flush;
  logic                overflow_flag;
  logic                ovf_trap_en;
  logic                in_ready;
  logic                out_load;
  logic                out_valid;
  logic                mc_start;
  logic                mc_abort;
  logic                mc_busy;
  logic [MC_LAT_W-1:0] mc_count;
  logic                ovf_trap;

  modport master (
    output in_valid, in_multicycle, in_latency, out_ready, flush,
           overflow_flag, ovf_trap_en,
    input  in_ready, out_load, out_valid, mc_start, mc_abort, mc_busy,
           mc_count, ovf_trap
  );

  modport slave (
    input  in_valid, in_multicycle, in_latency, out_ready, flush,
           overflow_flag, ovf_trap_en,
    output in_ready, out_load, out_valid, mc_start, mc_abort, mc_busy,
           mc_count, ovf_trap
  );
endinterface

// File: rtl/execute_stage_ctrl_mc_latency_counter.sv
// Down-counter tracking remaining multicycle cycles; saturates at 1 until cleared.
module mc_latency_counter
  import common::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                dec,
  input  logic                clr,
  input  logic [MC_LAT_W-1:0] load_val,
  output logic [MC_LAT_W-1:0] count,
  output logic                is_one
);
  logic [MC_LAT_W-1:0] count_p0;

  always_ff @(posedge clk) begin
    if (reset || clr)
      count_p0 <= '0;
    else if (load)
      count_p0 <= load_val;
    else if (dec && (count_p0 > MC_LAT_W'(1)))
      count_p0 <= count_p0 - MC_LAT_W'(1);
  end

  assign count  = count_p0;
  assign is_one = (count_p0 == MC_LAT_W'(1));
endmodule

// File: rtl/execute_stage_ctrl.sv
// Execute-stage control: issue handshake, multicycle sequencing, output register
// valid tracking, flush abort and overflow trap generation.
module execute_stage_ctrl
  import common::*;
(
  input  logic               clk,
  input  logic               reset,
  execute_stage_ctrl_if.slave bus
);
  exec_ctrl_state_t    state_p0, state_nxt;
  logic                vld_p1;
  logic                ovf_trap_p1;
  logic                slot_free, accept;
  logic                in_ready_c, out_load_c, mc_start_c, mc_abort_c;
  logic                cnt_load, cnt_dec, cnt_clr, cnt_is_one;
  logic [MC_LAT_W-1:0] cnt_value, lat_eff;

  assign slot_free  = !vld_p1 || bus.out_ready;
  assign in_ready_c = !reset && (state_p0 == IDLE) && slot_free && !bus.flush;
  assign accept     = bus.in_valid && in_ready_c;
  assign lat_eff    = (bus.in_latency == '0) ? MC_LAT_W'(1) : bus.in_latency;

  mc_latency_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .load_val (lat_eff),
    .count    (cnt_value),
    .is_one   (cnt_is_one)
  );

  always_ff @(posedge clk) begin
    if (reset) state_p0 <= IDLE;
    else       state_p0 <= state_nxt;
  end

  // Flush takes priority over completion in both busy states.
  always_comb begin
    state_nxt  = state_p0;
    out_load_c = 1'b0;
    mc_start_c = 1'b0;
    mc_abort_c = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_clr    = 1'b0;
    unique case (state_p0)
      IDLE: begin
        if (accept) begin
          if (bus.in_multicycle) begin
            mc_start_c = 1'b1;
            cnt_load   = 1'b1;
            state_nxt  = EXEC_MC;
          end else begin
            out_load_c = 1'b1;
          end
        end
      end
      EXEC_MC: begin
        if (bus.flush) begin
          mc_abort_c = 1'b1;
          cnt_clr    = 1'b1;
          state_nxt  = IDLE;
        end else if (cnt_is_one) begin
          if (slot_free) begin
            out_load_c = 1'b1;
            cnt_clr    = 1'b1;
            state_nxt  = IDLE;
          end else begin
            state_nxt  = WAIT_OUT;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAIT_OUT: begin
        if (bus.flush) begin
          mc_abort_c = 1'b1;
          cnt_clr    = 1'b1;
          state_nxt  = IDLE;
        end else if (slot_free) begin
          out_load_c = 1'b1;
          cnt_clr    = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      state_nxt  = IDLE;
      out_load_c = 1'b0;
      mc_start_c = 1'b0;
      mc_abort_c = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      cnt_clr    = 1'b0;
    end
  end

  // Output register valid and one-cycle-late overflow trap.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      ovf_trap_p1 <= 1'b0;
    end else begin
      if (out_load_c)         vld_p1 <= 1'b1;
      else if (bus.out_ready) vld_p1 <= 1'b0;
      ovf_trap_p1 <= out_load_c && bus.overflow_flag && bus.ovf_trap_en;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_load  = out_load_c;
  assign bus.out_valid = vld_p1;
  assign bus.mc_start  = mc_start_c;
  assign bus.mc_abort  = mc_abort_c;
  assign bus.mc_busy   = (state_p0 != IDLE);
  assign bus.mc_count  = cnt_value;
  assign bus.ovf_trap  = ovf_trap_p1;
endmodule
